serial_subtractor: RTL and testbench
====================================

Name: serial_subtractor

Overview:
Parametrised multi-cycle subtractor. Computes diff = a - b - borrow_in over WIDTH bits, SLICE bits per clock, LSB slice first. A registered borrow chains between slices. Used where a wide parallel subtractor is too costly; successor to the single-bit subtractor cells in Combinational_Circuits.

Parameters:
WIDTH, 8, operand/result width in bits; >= 2
SLICE, 1, bits processed per clock; must divide WIDTH exactly (elaboration error otherwise)

Ports:
clk  input  1  single clock, rising-edge
rst_n  input  1  asynchronous active-low reset
start  input  1  request; sampled on rising edge when idle or done
a  input  WIDTH  minuend, captured on accepted start
b  input  WIDTH  subtrahend, captured on accepted start
borrow_in  input  1  initial borrow, captured on accepted start
busy  output  1  high while in RUN
done  output  1  one-cycle pulse: result valid
diff  output  WIDTH  result; holds until the next operation completes
borrow_out  output  1  final borrow (1 when a < b + borrow_in, unsigned)

Behaviour:
- Reset (rst_n=0, async): state IDLE, busy=0, done=0, diff=0, borrow_out=0, slice counter=0, internal operand and borrow registers=0.
- N = WIDTH/SLICE. Counter is ceil(log2(N)) bits wide, minimum 1.
- States: IDLE, RUN, DONE.
- IDLE: start=1 -> capture a, b, borrow_in; counter=0; go to RUN. start=0 -> stay.
- RUN: each edge processes slice [counter*SLICE +: SLICE]: {br, d} = a_slice - b_slice - br_reg; write d into the result shift/accumulate register; br_reg <= br; counter++. After slice N-1: go to DONE; load diff and borrow_out.
- DONE: done=1 for exactly this cycle. start=1 -> capture new operands, go to RUN (back-to-back). Otherwise -> IDLE.
- Latency: done is high exactly N cycles after the edge that samples start. Throughput: one result per N+1 cycles.
- busy=1 only in RUN; done=1 only in DONE; never both at once.
- start during RUN is ignored; captured operands are not disturbed.
- a, b, borrow_in may change freely after capture.
- diff and borrow_out change only on the edge entering DONE (and on reset). They are stable in IDLE and RUN.
- Arithmetic is modulo 2^WIDTH. borrow_out is the unsigned borrow out of the MSB slice.
- Reset asserted mid-RUN: operation abandoned, all state per reset values, no done pulse.
- SLICE == WIDTH is legal: N=1, one RUN cycle.

Optional Feature:
Macro SERIAL_SUB_SIGNED_OVF_EN.
- Defined: extra output port ovf (1 bit, reset 0), updated alongside diff. ovf=1 when two's-complement overflow occurs: sign(a) != sign(b) and sign(diff) != sign(a). It uses the captured MSBs and the final result.
- Undefined: no ovf port, no related logic. All other behaviour is identical.

Test Plan:
- WIDTH=8, SLICE=1: a=0x5A, b=0x3C, borrow_in=0, start 1 cycle -> busy high 8 cycles; done pulses 8 cycles after start edge; diff=0x1E, borrow_out=0.
- WIDTH=8, SLICE=1: a=0x00, b=0x01, borrow_in=0 -> diff=0xFF, borrow_out=1. Then a=0x10, b=0x0F, borrow_in=1 -> diff=0x00, borrow_out=0.
- WIDTH=8, SLICE=4: a=0xA0, b=0x05 -> done 2 cycles after start, diff=0x9B, borrow_out=0. Start held high in the DONE cycle with a=0x01, b=0x02 -> immediate RUN; next done gives diff=0xFF, borrow_out=1.
- Start asserted with different operands in RUN cycle 3 -> ignored: result matches the first operands, exactly one done pulse.
- rst_n pulled low in RUN cycle 4, released 2 cycles later -> busy=0, done=0, diff=0, borrow_out=0; no done pulse until a new start.
- With SERIAL_SUB_SIGNED_OVF_EN, WIDTH=8: 0x80-0x01 -> diff=0x7F, ovf=1. 0x7F-0xFF -> diff=0x80, ovf=1. 0x05-0x03 -> ovf=0.

Source files
------------

// File: rtl/serial_subtractor_if.sv
// Operand/result bundle for serial_subtractor; master drives start and operands, slave returns status and result.
// SERIAL_SUB_SIGNED_OVF_EN adds the signed-overflow flag ovf.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             borrow_in;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] diff;
  logic             borrow_out;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic             ovf;
`endif

  modport master (
    output start, a, b, borrow_in,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    input  ovf,
`endif
    input  busy, done, diff, borrow_out
  );

  modport slave (
    input  start, a, b, borrow_in,
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    output ovf,
`endif
    output busy, done, diff, borrow_out
  );
endinterface

// File: rtl/serial_subtractor.sv
// Multi-cycle a - b - borrow_in, SLICE bits per clock LSB first; done N=WIDTH/SLICE cycles after start, one result per N+1.
// No output stall: start is ignored during RUN. SERIAL_SUB_SIGNED_OVF_EN adds the signed overflow output ovf.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int SLICE = 1
) (
  input logic            clk,
  input logic            rst_n,
  serial_subtractor_if.slave bus
);
  localparam int N  = WIDTH / SLICE;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if (WIDTH < 2 || SLICE < 1 || (WIDTH % SLICE) != 0) begin : g_param_check
    $error("serial_subtractor: SLICE must divide WIDTH and WIDTH must be >= 2");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state, state_nxt;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_reg, b_reg, acc, acc_nxt, diff_q;
  logic             br_reg, bout_q;
  logic [SLICE:0]   sub;
  logic             last, accept;
  int               idx;

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    last      = (cnt == CW'(N - 1));
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = RUN;
          accept    = 1'b1;
        end
      end
      RUN: begin
        if (last) state_nxt = DONE;
      end
      DONE: begin
        accept    = bus.start;
        state_nxt = bus.start ? RUN : IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // One slice of the ripple: the top bit of the (SLICE+1)-bit difference is the borrow.
  always_comb begin
    idx     = int'(cnt) * SLICE;
    sub     = {1'b0, a_reg[idx +: SLICE]} - {1'b0, b_reg[idx +: SLICE]} - (SLICE+1)'(br_reg);
    acc_nxt = acc;
    acc_nxt[idx +: SLICE] = sub[SLICE-1:0];
  end

  assign bus.busy       = (state == RUN);
  assign bus.done       = (state == DONE);
  assign bus.diff       = diff_q;
  assign bus.borrow_out = bout_q;

`ifdef SERIAL_SUB_SIGNED_OVF_EN
  logic ovf_q;
  assign bus.ovf = ovf_q;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      a_reg  <= '0;
      b_reg  <= '0;
      br_reg <= 1'b0;
      acc    <= '0;
      diff_q <= '0;
      bout_q <= 1'b0;
`ifdef SERIAL_SUB_SIGNED_OVF_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (accept) begin
        a_reg  <= bus.a;
        b_reg  <= bus.b;
        br_reg <= bus.borrow_in;
        cnt    <= '0;
      end else if (state == RUN) begin
        acc    <= acc_nxt;
        br_reg <= sub[SLICE];
        cnt    <= cnt + 1'b1;
        if (last) begin
          diff_q <= acc_nxt;
          bout_q <= sub[SLICE];
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          // Operand MSBs are never shifted, so a_reg/b_reg still hold the signs.
          ovf_q  <= (a_reg[WIDTH-1] ^ b_reg[WIDTH-1]) & (acc_nxt[WIDTH-1] ^ a_reg[WIDTH-1]);
`endif
        end
      end
    end
  end
endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench: two DUTs (SLICE=1 and SLICE=4, WIDTH=8) share one stimulus stream.
// Each has a cycle-level acceptance model feeding an expected-result queue and a monitor popping it on done.
module tb_serial_subtractor;
  localparam int W = 8;

  typedef struct {
    logic [W-1:0] diff;
    logic         bout;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         st = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         op_bin = 1'b0;

  int n_chk = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
  endtask

  for (genvar g = 0; g < 2; g++) begin : g_dut
    localparam int SL = (g == 0) ? 1 : 4;
    localparam int N  = W / SL;

    serial_subtractor_if #(.WIDTH(W)) bus ();
    assign bus.start     = st;
    assign bus.a         = op_a;
    assign bus.b         = op_b;
    assign bus.borrow_in = op_bin;

    serial_subtractor #(.WIDTH(W), .SLICE(SL)) dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
    );

    exp_t         q[$];
    int           e = 0;
    int           next_ok = 0;
    int           last_acc = -1;
    int           last_due = -1;
    logic [W-1:0] last_diff = '0;
    logic         last_bout = 1'b0;
    logic         last_ovf = 1'b0;

    // Reference: a start is taken whenever the previous job has reached its done cycle.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        q.delete();
        next_ok  = 0;
        last_acc = -1;
        last_due = -1;
      end else begin
        e = e + 1;
        if (st && e >= next_ok) begin
          exp_t x;
          int   full;
          full   = int'(op_a) - int'(op_b) - int'(op_bin);
          x.diff = W'(full);
          x.bout = (full < 0);
          x.ovf  = (op_a[W-1] != op_b[W-1]) && (x.diff[W-1] != op_a[W-1]);
          x.due  = e + N;
          q.push_back(x);
          last_acc = e;
          last_due = e + N;
          next_ok  = e + N + 1;
        end
      end
    end

    always @(negedge clk) begin
      if (!rst_n) begin
        last_diff = '0;
        last_bout = 1'b0;
        last_ovf  = 1'b0;
      end else begin
        chk($sformatf("s%0d_busy", SL), int'(bus.busy), int'(e >= last_acc && e < last_due));
        chk($sformatf("s%0d_done", SL), int'(bus.done), int'(e == last_due));
        if (bus.done) begin
          chk($sformatf("s%0d_done_has_job", SL), int'(q.size() > 0), 1);
          if (q.size() > 0) begin
            exp_t x;
            x = q.pop_front();
            chk($sformatf("s%0d_latency", SL), e, x.due);
            chk($sformatf("s%0d_diff", SL), int'(bus.diff), int'(x.diff));
            chk($sformatf("s%0d_borrow_out", SL), int'(bus.borrow_out), int'(x.bout));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
            chk($sformatf("s%0d_ovf", SL), int'(bus.ovf), int'(x.ovf));
`endif
            last_diff = x.diff;
            last_bout = x.bout;
            last_ovf  = x.ovf;
          end
        end else begin
          chk($sformatf("s%0d_diff_hold", SL), int'(bus.diff), int'(last_diff));
          chk($sformatf("s%0d_bout_hold", SL), int'(bus.borrow_out), int'(last_bout));
`ifdef SERIAL_SUB_SIGNED_OVF_EN
          chk($sformatf("s%0d_ovf_hold", SL), int'(bus.ovf), int'(last_ovf));
`endif
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic rst_vals(input string tag, input logic bsy, input logic dn,
                          input logic [W-1:0] d, input logic bo);
    chk({tag, "_rst_busy"}, int'(bsy), 0);
    chk({tag, "_rst_done"}, int'(dn), 0);
    chk({tag, "_rst_diff"}, int'(d), 0);
    chk({tag, "_rst_bout"}, int'(bo), 0);
  endtask

  task automatic rst_check();
    @(negedge clk);
    rst_vals("s1", g_dut[0].bus.busy, g_dut[0].bus.done, g_dut[0].bus.diff, g_dut[0].bus.borrow_out);
    rst_vals("s4", g_dut[1].bus.busy, g_dut[1].bus.done, g_dut[1].bus.diff, g_dut[1].bus.borrow_out);
`ifdef SERIAL_SUB_SIGNED_OVF_EN
    chk("s1_rst_ovf", int'(g_dut[0].bus.ovf), 0);
    chk("s4_rst_ovf", int'(g_dut[1].bus.ovf), 0);
`endif
  endtask

  int dir_a[9]   = '{'h5A, 'h00, 'h10, 'hA0, 'h01, 'h80, 'h7F, 'h05, 'hFF};
  int dir_b[9]   = '{'h3C, 'h01, 'h0F, 'h05, 'h02, 'h01, 'hFF, 'h03, 'hFF};
  int dir_bin[9] = '{0,    0,    1,    0,    0,    0,    0,    0,    1};

  initial begin
    repeat (3) step();
    rst_check();
    step();
    rst_n = 1'b1;
    step();

    // Directed single-pulse operations, fully drained between each.
    for (int i = 0; i < 9; i++) begin
      st     = 1'b1;
      op_a   = W'(dir_a[i]);
      op_b   = W'(dir_b[i]);
      op_bin = dir_bin[i][0];
      step();
      st = 1'b0;
      repeat (10) step();
    end

    // Start held high: ignored during RUN, re-accepted in DONE (back-to-back).
    st = 1'b1; op_a = 8'hA0; op_b = 8'h05; op_bin = 1'b0;
    step();
    op_a = 8'h01; op_b = 8'h02;
    repeat (12) step();
    st = 1'b0;
    repeat (12) step();

    // Reset in RUN cycle 4: job abandoned, no done afterwards.
    st = 1'b1; op_a = 8'h5A; op_b = 8'h3C; op_bin = 1'b0;
    step();
    st = 1'b0;
    repeat (3) step();
    rst_n = 1'b0;
    rst_check();
    step();
    step();
    rst_n = 1'b1;
    repeat (12) step();

    // Random traffic, including starts that land during RUN.
    repeat (1500) begin
      st     = ($urandom % 3) == 0;
      op_a   = W'($urandom);
      op_b   = W'($urandom);
      op_bin = 1'($urandom);
      step();
    end
    st = 1'b0;
    repeat (12) step();

    chk("s1_pending_jobs", g_dut[0].q.size(), 0);
    chk("s4_pending_jobs", g_dut[1].q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
